// File: rtl/flow_state_rd_arbiter_n.sv
// N-client round-robin arbiter that issues paired tx_state/recv_state reads and returns joined responses in order.
// Optional perf counters are built when FLOW_STATE_RD_ARB_PERF_EN is defined; state widths stand in for the tcp_pkg types.
module flow_state_rd_arbiter_n #(
    parameter int NUM_CLIENTS     = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int FLOWID_W        = 16,
    parameter int TX_STATE_W      = 64,
    parameter int RX_STATE_W      = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,

    input  logic [NUM_CLIENTS-1:0]          client_rd_req_val,
    input  logic [NUM_CLIENTS*FLOWID_W-1:0] client_rd_req_flowid,
    output logic [NUM_CLIENTS-1:0]          client_rd_req_grant,

    output logic                            tx_state_rd_req_val,
    output logic [FLOWID_W-1:0]             tx_state_rd_req_flowid,
    input  logic                            tx_state_rd_req_rdy,
    output logic                            rx_state_rd_req_val,
    output logic [FLOWID_W-1:0]             rx_state_rd_req_flowid,
    input  logic                            rx_state_rd_req_rdy,

    input  logic                            tx_state_rd_resp_val,
    input  logic [TX_STATE_W-1:0]           tx_state_rd_resp_data,
    output logic                            tx_state_rd_resp_rdy,
    input  logic                            rx_state_rd_resp_val,
    input  logic [RX_STATE_W-1:0]           rx_state_rd_resp_data,
    output logic                            rx_state_rd_resp_rdy,

    output logic [NUM_CLIENTS-1:0]          client_rd_resp_val,
    output logic [TX_STATE_W-1:0]           client_tx_state_rd_resp_data,
    output logic [RX_STATE_W-1:0]           client_rx_state_rd_resp_data,
    input  logic [NUM_CLIENTS-1:0]          client_rd_resp_rdy,

`ifdef FLOW_STATE_RD_ARB_PERF_EN
    output logic [NUM_CLIENTS*32-1:0]       perf_grant_cnt,
    output logic [31:0]                     perf_full_stall_cnt,
`endif
    output logic                            err_unexpected_resp
);

    localparam int CLIENT_W = $clog2(NUM_CLIENTS);
    localparam int PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W    = $clog2(MAX_OUTSTANDING) + 1;

    localparam logic [CNT_W-1:0]    CNT_FULL    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0]    PTR_LAST    = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CLIENT_W-1:0] CLIENT_LAST = CLIENT_W'(NUM_CLIENTS - 1);
    localparam logic [CLIENT_W:0]   CLIENT_NUM  = (CLIENT_W + 1)'(NUM_CLIENTS);

    logic [CLIENT_W-1:0] prio_q, prio_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                err_q, err_d;
    logic [CLIENT_W-1:0] tag_q [MAX_OUTSTANDING];
    logic [CLIENT_W-1:0] tag_d [MAX_OUTSTANDING];

    logic [FLOWID_W-1:0] flowid_arr [NUM_CLIENTS];
    logic [CLIENT_W-1:0] winner;
    logic [CLIENT_W-1:0] head;
    logic                any_req;
    logic                full;
    logic                empty;
    logic                issue;
    logic                join_val;
    logic                pop;

    for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_flowid
        assign flowid_arr[g] = client_rd_req_flowid[g*FLOWID_W +: FLOWID_W];
    end

    // Rotating search starting at prio_q, which holds last winner + 1.
    always_comb begin
        logic [CLIENT_W:0]   sum;
        logic [CLIENT_W-1:0] idx;
        winner  = '0;
        any_req = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int off = 0; off < NUM_CLIENTS; off++) begin
            sum = {1'b0, prio_q} + (CLIENT_W + 1)'(off);
            if (sum >= CLIENT_NUM) begin
                sum = sum - CLIENT_NUM;
            end
            idx = sum[CLIENT_W-1:0];
            if (!any_req && client_rd_req_val[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign issue = any_req & tx_state_rd_req_rdy & rx_state_rd_req_rdy & ~full;
    assign head  = tag_q[rd_ptr_q];

    always_comb begin
        client_rd_req_grant    = '0;
        tx_state_rd_req_val    = issue;
        rx_state_rd_req_val    = issue;
        tx_state_rd_req_flowid = '0;
        if (issue) begin
            client_rd_req_grant    = NUM_CLIENTS'(1) << winner;
            tx_state_rd_req_flowid = flowid_arr[winner];
        end
        rx_state_rd_req_flowid = tx_state_rd_req_flowid;
    end

    // A lone tx or rx response is held until its partner arrives.
    always_comb begin
        join_val           = tx_state_rd_resp_val & rx_state_rd_resp_val & ~empty;
        pop                = join_val & client_rd_resp_rdy[head];
        client_rd_resp_val = '0;
        if (join_val) begin
            client_rd_resp_val = NUM_CLIENTS'(1) << head;
        end
        tx_state_rd_resp_rdy = pop;
        rx_state_rd_resp_rdy = pop;
    end

    assign client_tx_state_rd_resp_data = tx_state_rd_resp_data;
    assign client_rx_state_rd_resp_data = rx_state_rd_resp_data;
    assign err_unexpected_resp          = err_q;

    always_comb begin
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        prio_d   = prio_q;
        if (issue) begin
            tag_d[wr_ptr_q] = winner;
            wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            prio_d          = (winner == CLIENT_LAST) ? '0 : winner + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({issue, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        err_d = err_q | ((tx_state_rd_resp_val | rx_state_rd_resp_val) & empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            prio_q   <= prio_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Tag slots are only read while occupied, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

`ifdef FLOW_STATE_RD_ARB_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;

    for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_perf_grant
        logic [31:0] grant_cnt_q, grant_cnt_d;

        always_comb begin
            grant_cnt_d = grant_cnt_q;
            if (client_rd_req_grant[g] && (grant_cnt_q != 32'hFFFF_FFFF)) begin
                grant_cnt_d = grant_cnt_q + 32'd1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                grant_cnt_q <= '0;
            end else begin
                grant_cnt_q <= grant_cnt_d;
            end
        end

        assign perf_grant_cnt[g*32 +: 32] = grant_cnt_q;
    end

    always_comb begin
        perf_stall_d = perf_stall_q;
        if (any_req && tx_state_rd_req_rdy && rx_state_rd_req_rdy && full &&
            (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_full_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_flow_state_rd_arbiter_n.sv
// Directed self-checking bench for flow_state_rd_arbiter_n with 3 clients and a 4-deep order queue.
module tb_flow_state_rd_arbiter_n;

    localparam int NC  = 3;
    localparam int FW  = 8;
    localparam int TXW = 16;
    localparam int RXW = 16;

    logic            clk;
    logic            rst_n;
    logic [NC-1:0]   req_val;
    logic [NC*FW-1:0] req_flowid;
    logic [NC-1:0]   grant;
    logic            tx_req_val, rx_req_val;
    logic [FW-1:0]   tx_req_flowid, rx_req_flowid;
    logic            tx_req_rdy, rx_req_rdy;
    logic            tx_resp_val, rx_resp_val;
    logic [TXW-1:0]  tx_resp_data;
    logic [RXW-1:0]  rx_resp_data;
    logic            tx_resp_rdy, rx_resp_rdy;
    logic [NC-1:0]   client_resp_val;
    logic [TXW-1:0]  client_tx_data;
    logic [RXW-1:0]  client_rx_data;
    logic [NC-1:0]   client_resp_rdy;
    logic            err;

    int n_compared;
    int n_mismatched;

    flow_state_rd_arbiter_n #(
        .NUM_CLIENTS(NC),
        .MAX_OUTSTANDING(4),
        .FLOWID_W(FW),
        .TX_STATE_W(TXW),
        .RX_STATE_W(RXW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .client_rd_req_val(req_val),
        .client_rd_req_flowid(req_flowid),
        .client_rd_req_grant(grant),
        .tx_state_rd_req_val(tx_req_val),
        .tx_state_rd_req_flowid(tx_req_flowid),
        .tx_state_rd_req_rdy(tx_req_rdy),
        .rx_state_rd_req_val(rx_req_val),
        .rx_state_rd_req_flowid(rx_req_flowid),
        .rx_state_rd_req_rdy(rx_req_rdy),
        .tx_state_rd_resp_val(tx_resp_val),
        .tx_state_rd_resp_data(tx_resp_data),
        .tx_state_rd_resp_rdy(tx_resp_rdy),
        .rx_state_rd_resp_val(rx_resp_val),
        .rx_state_rd_resp_data(rx_resp_data),
        .rx_state_rd_resp_rdy(rx_resp_rdy),
        .client_rd_resp_val(client_resp_val),
        .client_tx_state_rd_resp_data(client_tx_data),
        .client_rx_state_rd_resp_data(client_rx_data),
        .client_rd_resp_rdy(client_resp_rdy),
        .err_unexpected_resp(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge, then waits to the falling edge for checks.
    task automatic applyStimulus(input logic [NC-1:0] rv, input logic [NC-1:0] crdy,
                                 input logic txv, input logic rxv, input logic [FW-1:0] fid);
        @(posedge clk);
        #1;
        req_val         = rv;
        client_resp_rdy = crdy;
        tx_resp_val     = txv;
        rx_resp_val     = rxv;
        tx_resp_data    = {8'hA5, fid};
        rx_resp_data    = {8'h5A, fid};
        @(negedge clk);
    endtask

    int exp1 [6] = '{0, 1, 2, 0, 1, 2};
    int exp2 [4] = '{0, 1, 2, 0};
    int drn2 [4] = '{1, 2, 0, 1};

    initial begin
        logic [FW-1:0] f;
        n_compared      = 0;
        n_mismatched    = 0;
        rst_n           = 1'b0;
        req_val         = '0;
        req_flowid      = {8'h12, 8'h11, 8'h10};
        tx_req_rdy      = 1'b1;
        rx_req_rdy      = 1'b1;
        tx_resp_val     = 1'b0;
        rx_resp_val     = 1'b0;
        tx_resp_data    = '0;
        rx_resp_data    = '0;
        client_resp_rdy = '1;

        #12;
        checkOutput("rst_grant", 32'(grant), 32'h0);
        checkOutput("rst_req_val", 32'(tx_req_val), 32'h0);
        checkOutput("rst_resp_val", 32'(client_resp_val), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] continuous round robin with 2-cycle response latency");
        for (int c = 0; c < 8; c++) begin
            logic rsp;
            rsp = (c >= 2);
            f   = rsp ? 8'h10 + 8'(exp1[c-2]) : 8'h00;
            applyStimulus((c < 6) ? 3'b111 : 3'b000, 3'b111, rsp, rsp, f);
            if (c < 6) begin
                checkOutput("t1_grant", 32'(grant), 32'(1 << exp1[c]));
                checkOutput("t1_req_flowid", 32'(tx_req_flowid), 32'(8'h10 + 8'(exp1[c])));
                checkOutput("t1_rx_req_val", 32'(rx_req_val), 32'h1);
            end else begin
                checkOutput("t1_idle_grant", 32'(grant), 32'h0);
            end
            if (rsp) begin
                checkOutput("t1_resp_val", 32'(client_resp_val), 32'(1 << exp1[c-2]));
                checkOutput("t1_tx_data", 32'(client_tx_data), 32'({8'hA5, f}));
                checkOutput("t1_rx_data", 32'(client_rx_data), 32'({8'h5A, f}));
                checkOutput("t1_tx_resp_rdy", 32'(tx_resp_rdy), 32'h1);
            end
        end

        $display("[TB] queue fills at 4 and a single pop frees one slot");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(3'b111, 3'b111, 1'b0, 1'b0, 8'h00);
            checkOutput("t2_grant", 32'(grant), 32'(1 << exp2[k]));
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(3'b111, 3'b111, 1'b0, 1'b0, 8'h00);
            checkOutput("t2_full_req_val", 32'(tx_req_val), 32'h0);
            checkOutput("t2_full_grant", 32'(grant), 32'h0);
        end
        applyStimulus(3'b111, 3'b111, 1'b1, 1'b1, 8'h10);
        checkOutput("t2_pop_resp_val", 32'(client_resp_val), 32'h1);
        checkOutput("t2_pop_rx_rdy", 32'(rx_resp_rdy), 32'h1);
        checkOutput("t2_pop_same_cycle_grant", 32'(grant), 32'h0);
        applyStimulus(3'b111, 3'b111, 1'b0, 1'b0, 8'h00);
        checkOutput("t2_refill_grant", 32'(grant), 32'h2);
        checkOutput("t2_refill_flowid", 32'(rx_req_flowid), 32'h11);
        applyStimulus(3'b111, 3'b111, 1'b0, 1'b0, 8'h00);
        checkOutput("t2_refull_req_val", 32'(tx_req_val), 32'h0);
        for (int k = 0; k < 4; k++) begin
            f = 8'h10 + 8'(drn2[k]);
            applyStimulus(3'b000, 3'b111, 1'b1, 1'b1, f);
            checkOutput("t2_drain_resp_val", 32'(client_resp_val), 32'(1 << drn2[k]));
            checkOutput("t2_drain_tx_rdy", 32'(tx_resp_rdy), 32'h1);
        end

        $display("[TB] tx response arrives 3 cycles ahead of rx");
        applyStimulus(3'b010, 3'b111, 1'b0, 1'b0, 8'h00);
        checkOutput("t3_grant", 32'(grant), 32'h2);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(3'b000, 3'b111, 1'b1, 1'b0, 8'h11);
            checkOutput("t3_lone_resp_val", 32'(client_resp_val), 32'h0);
            checkOutput("t3_lone_tx_rdy", 32'(tx_resp_rdy), 32'h0);
            checkOutput("t3_lone_rx_rdy", 32'(rx_resp_rdy), 32'h0);
        end
        applyStimulus(3'b000, 3'b111, 1'b1, 1'b1, 8'h11);
        checkOutput("t3_join_resp_val", 32'(client_resp_val), 32'h2);
        checkOutput("t3_join_tx_rdy", 32'(tx_resp_rdy), 32'h1);
        checkOutput("t3_join_rx_data", 32'(client_rx_data), 32'h5A11);

        $display("[TB] head client back-pressures for 5 cycles");
        applyStimulus(3'b101, 3'b111, 1'b0, 1'b0, 8'h00);
        checkOutput("t4_grant_a", 32'(grant), 32'h4);
        applyStimulus(3'b001, 3'b111, 1'b0, 1'b0, 8'h00);
        checkOutput("t4_grant_b", 32'(grant), 32'h1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(3'b000, 3'b011, 1'b1, 1'b1, 8'h12);
            checkOutput("t4_stall_resp_val", 32'(client_resp_val), 32'h4);
            checkOutput("t4_stall_tx_rdy", 32'(tx_resp_rdy), 32'h0);
            checkOutput("t4_stall_rx_rdy", 32'(rx_resp_rdy), 32'h0);
        end
        applyStimulus(3'b000, 3'b111, 1'b1, 1'b1, 8'h12);
        checkOutput("t4_release_resp_val", 32'(client_resp_val), 32'h4);
        checkOutput("t4_release_tx_rdy", 32'(tx_resp_rdy), 32'h1);
        applyStimulus(3'b000, 3'b111, 1'b1, 1'b1, 8'h10);
        checkOutput("t4_second_resp_val", 32'(client_resp_val), 32'h1);
        checkOutput("t4_second_rx_rdy", 32'(rx_resp_rdy), 32'h1);
        checkOutput("t4_no_err", 32'(err), 32'h0);

        $display("[TB] unexpected response with empty queue");
        applyStimulus(3'b000, 3'b111, 1'b0, 1'b1, 8'h00);
        checkOutput("t5_resp_val", 32'(client_resp_val), 32'h0);
        checkOutput("t5_rx_rdy", 32'(rx_resp_rdy), 32'h0);
        checkOutput("t5_tx_rdy", 32'(tx_resp_rdy), 32'h0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(3'b000, 3'b111, 1'b0, 1'b0, 8'h00);
            checkOutput("t5_err_sticky", 32'(err), 32'h1);
        end
        rst_n = 1'b0;
        #2;
        checkOutput("t5_err_cleared", 32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] reset with 3 reads outstanding");
        applyStimulus(3'b010, 3'b111, 1'b0, 1'b0, 8'h00);
        checkOutput("t6_pre_grant_a", 32'(grant), 32'h2);
        applyStimulus(3'b100, 3'b111, 1'b0, 1'b0, 8'h00);
        checkOutput("t6_pre_grant_b", 32'(grant), 32'h4);
        applyStimulus(3'b010, 3'b111, 1'b0, 1'b0, 8'h00);
        checkOutput("t6_pre_grant_c", 32'(grant), 32'h2);
        req_val = '0;
        rst_n   = 1'b0;
        #3;
        rst_n   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(3'b111, 3'b111, 1'b0, 1'b0, 8'h00);
            checkOutput("t6_post_grant", 32'(grant), 32'(1 << exp2[k]));
        end
        applyStimulus(3'b111, 3'b111, 1'b0, 1'b0, 8'h00);
        checkOutput("t6_post_full", 32'(tx_req_val), 32'h0);
        applyStimulus(3'b000, 3'b111, 1'b1, 1'b1, 8'h10);
        checkOutput("t6_post_head", 32'(client_resp_val), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/flow_state_rd_arbiter_n.md
Name: flow_state_rd_arbiter_n

Overview:
N-client arbiter for paired TX-state / RX-state table reads in the recv pipe. Each client issues one flowid, which produces a read of both the tx_state and recv_state tables. Up to MAX_OUTSTANDING joined reads may be in flight; responses are paired and returned in order to the client that issued each read. This block replaces the fixed 2-client, single-outstanding FSM/EST arbiter and sits between the recv-pipe stages and the state memories.

Parameters:
NUM_CLIENTS, 2, number of requesting clients (2..8)
MAX_OUTSTANDING, 4, depth of the in-flight order queue (power of 2, 1..16)
FLOWID_W, tcp_pkg::FLOWID_W, flow id width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
client_rd_req_val  in  NUM_CLIENTS  per-client read request
client_rd_req_flowid  in  NUM_CLIENTS*FLOWID_W  packed; client i at [i*FLOWID_W +: FLOWID_W]
client_rd_req_grant  out  NUM_CLIENTS  one-hot; request accepted this cycle
tx_state_rd_req_val / rx_state_rd_req_val  out  1  memory read issue, always driven equal
tx_state_rd_req_flowid / rx_state_rd_req_flowid  out  FLOWID_W  granted flowid
tx_state_rd_req_rdy / rx_state_rd_req_rdy  in  1  memory accept
tx_state_rd_resp_val  in  1 ; tx_state_rd_resp_data  in  tx_state_struct ; tx_state_rd_resp_rdy  out  1
rx_state_rd_resp_val  in  1 ; rx_state_rd_resp_data  in  recv_state_entry ; rx_state_rd_resp_rdy  out  1
client_rd_resp_val  out  NUM_CLIENTS  one-hot; joined response valid
client_tx_state_rd_resp_data  out  tx_state_struct  broadcast to all clients
client_rx_state_rd_resp_data  out  recv_state_entry  broadcast to all clients
client_rd_resp_rdy  in  NUM_CLIENTS  per-client accept
err_unexpected_resp  out  1  sticky; a response arrived with no read outstanding

Behaviour:
- Async reset: all outputs 0; order queue empty; RR pointer 0; error flag cleared. A reset asserted mid-transaction discards all in-flight tags. Memory responses for those reads are not delivered to clients.
- Issue condition: some client_rd_req_val, both req_rdy high, and queue not full. When it holds, both req_val go high in the same cycle, and grant goes one-hot to the RR winner. The winner's index is pushed to the queue.
- Both req_val are combinational on rdy. The two tables must accept in the same cycle; one req_val is never asserted without the other.
- Round robin: search starts at last_granted+1 mod NUM_CLIENTS. At reset, client 0 has highest priority. The pointer updates only on issue.
- A full queue blocks issue, even if a pop happens in the same cycle. No rdy-to-req combinational path is allowed.
- Response join: client_rd_resp_val[head] = tx_resp_val & rx_resp_val & !empty. All other bits are 0.
- tx_resp_rdy = rx_resp_rdy = !empty & tx_resp_val & rx_resp_val & client_rd_resp_rdy[head]. Both memory responses are consumed in the same cycle.
- A lone tx or rx response with no partner is held, not acked.
- Pop occurs on a joined handshake. Push and pop in the same cycle leave the count unchanged.
- Data is passed through combinationally. Response latency from memory to client is 0 cycles. Minimum issue-to-issue spacing is 1 cycle.
- Queue pointers wrap modulo MAX_OUTSTANDING. The count register is $clog2(MAX_OUTSTANDING)+1 bits wide.
- If either resp_val is high while the queue is empty: both resp_rdy stay 0, and err_unexpected_resp sets and stays set until reset.
- Client requests are held until granted. The block does not check request stability.

Optional Feature:
FLOW_STATE_RD_ARB_PERF_EN
- Defined: adds the output perf_grant_cnt (NUM_CLIENTS*32) and the output perf_full_stall_cnt (32).
- perf_grant_cnt: per-client saturating grant counters.
- perf_full_stall_cnt: counts cycles in which a request was pending, both req_rdy were high, and the queue was full.
- Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: these ports and their logic are absent. Functional behaviour is identical.

Test Plan:
- NUM_CLIENTS=3; all clients request continuously with rdy=1 and responses returned 2 cycles later -> grants 0,1,2,0,1,2; each client_rd_resp_val matches its issue order with the correct flowid data.
- MAX_OUTSTANDING=4; responses withheld -> exactly 4 grants, then req_val=0; one joined response -> exactly one more grant, issued the following cycle.
- tx_resp_val high 3 cycles before rx_resp_val -> no client_rd_resp_val and no resp_rdy until both are high; then a single handshake pops the queue.
- Head client's rdy=0 for 5 cycles -> resp_val held, resp_rdy=0 on both memories, queue count unchanged; another client's rdy=1 has no effect.
- rx_resp_val pulsed with empty queue -> err_unexpected_resp=1 and sticky; resp_rdy=0; rst_n low -> flag 0 and queue empty.
- Reset with 3 reads outstanding -> after release, grants restart at client 0 and count=0.
